// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// Imported by the arbiter top and the busy scoreboard.
package regfile_pkg;

  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int RW   = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for results owed by the long-latency unit.
// Issue sets, accept clears, set wins; r0 is never busy.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_set,
  input  logic [$clog2(NREG)-1:0] i_set_rd,
  input  logic                    i_clr,
  input  logic [$clog2(NREG)-1:0] i_clr_rd,
  input  logic [$clog2(NREG)-1:0] i_chk_rs,
  input  logic [$clog2(NREG)-1:0] i_chk_rt,
  input  logic [$clog2(NREG)-1:0] i_chk_rd,
  output logic                    o_hazard
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr) w_busy_nxt[i_clr_rd] = 1'b0;
    if (i_set) w_busy_nxt[i_set_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  // Lookup uses the flops only; a same-cycle clear is seen next cycle.
  assign o_hazard = r_busy[i_chk_rs]
                  | r_busy[i_chk_rt]
                  | r_busy[i_chk_rd];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback and the
// long-latency unit, with starvation hold and busy scoreboard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREG         = regfile_pkg::NREG,
  parameter int DW           = regfile_pkg::DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [DW-1:0]           wb_data,
  input  logic                    lu_valid,
  input  logic [$clog2(NREG)-1:0] lu_rd,
  input  logic [DW-1:0]           lu_data,
  output logic                    lu_ready,
  input  logic                    iss_valid,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  input  logic [$clog2(NREG)-1:0] chk_rs,
  input  logic [$clog2(NREG)-1:0] chk_rt,
  input  logic [$clog2(NREG)-1:0] chk_rd,
  output logic                    hazard,
  output logic                    pipe_hold,
  output logic                    rf_we,
  output logic [$clog2(NREG)-1:0] rf_rd,
  output logic [DW-1:0]           rf_wdata
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic          w_lu_ready;
  logic          w_refused;
  logic          w_grant;
  logic [AW-1:0] w_g_rd;
  logic [DW-1:0] w_g_data;

  logic          r_we;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_wdata;
  logic          r_hold;

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  assign w_lu_ready = lu_valid & ~wb_valid;
  assign w_refused  = lu_valid & wb_valid;
  assign w_grant    = wb_valid | w_lu_ready;

  always_comb begin
    w_g_rd   = '0;
    w_g_data = '0;
    unique case (1'b1)
      wb_valid: begin
        w_g_rd   = wb_rd;
        w_g_data = wb_data;
      end
      w_lu_ready: begin
        w_g_rd   = lu_rd;
        w_g_data = lu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_grant & (w_g_rd != '0);
      if (w_grant) begin
        r_rd    <= w_g_rd;
        r_wdata <= w_g_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_refused) begin
          w_cnt_nxt   = ONE;
          w_state_nxt = (ONE >= LIM) ? HOLD : WAIT;
        end
      end
      WAIT: begin
        if (!lu_valid || w_lu_ready) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
          if (r_cnt + ONE >= LIM) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!lu_valid || w_lu_ready) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Hold is registered from the next state so it drops on the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= (w_state_nxt == HOLD);
    end
  end

  reg_scoreboard #(
    .NREG(NREG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .i_set    (iss_valid & (iss_rd != '0)),
    .i_set_rd (iss_rd),
    .i_clr    (w_lu_ready),
    .i_clr_rd (lu_rd),
    .i_chk_rs (chk_rs),
    .i_chk_rt (chk_rt),
    .i_chk_rd (chk_rd),
    .o_hazard (hazard)
  );

  assign lu_ready  = w_lu_ready;
  assign pipe_hold = r_hold;
  assign rf_we     = r_we;
  assign rf_rd     = r_rd;
  assign rf_wdata  = r_wdata;

endmodule
